// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline sequencer for the 5-stage MIPS core.
// Handles load-use bubbles, data-memory wait freezes and taken-branch flushes.
// Optional perf counters are compiled in with `define HAZARD_PERF_EN.
module hazard_stall_ctrl #(
    parameter int LU_BUBBLES  = 1,   // bubbles per load-use hazard, 1..7
    parameter int MEM_TIMEOUT = 64   // max MEMWAIT cycles before ERR, 2..255
`ifdef HAZARD_PERF_EN
    , parameter int CNT_W     = 16   // perf counter width
`endif
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] IFID_RegRS_i,
    input  logic [4:0] IFID_RegRT_i,
    input  logic       IDEX_MemRead_i,
    input  logic [4:0] IDEX_RegRT_i,
    input  logic       Branch_taken_i,
    input  logic       EXMEM_MemAccess_i,
    input  logic       DMem_ack_i,
    output logic       PCWrite_o,
    output logic       IFIDWrite_o,
    output logic       IFIDFlush_o,
    output logic       IDEXBubble_o,
    output logic       PipeStall_o,
    output logic       MemTimeout_o,
    output logic [1:0] State_o
`ifdef HAZARD_PERF_EN
    , output logic [CNT_W-1:0] StallCycles_o
    , output logic [CNT_W-1:0] FlushCnt_o
`endif
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_BUBBLE  = 2'd1,
        S_MEMWAIT = 2'd2,
        S_ERR     = 2'd3
    } state_t;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;   // bubbles left in BUBBLE, wait cycles in MEMWAIT

    logic lu, mw;

    // Decision a RUN cycle would make; also reused when MEMWAIT releases on ack
    state_t     run_next;
    logic [7:0] run_cnt;
    logic       run_pcw, run_ifw, run_flush, run_bub, run_stall;

    // Hazard detection
    always_comb begin
        lu = IDEX_MemRead_i && (IDEX_RegRT_i != 5'd0) &&
             ((IDEX_RegRT_i == IFID_RegRS_i) || (IDEX_RegRT_i == IFID_RegRT_i));
        mw = EXMEM_MemAccess_i && !DMem_ack_i;
    end

    // RUN-time priority: memory freeze beats load-use, load-use beats branch flush
    always_comb begin
        run_next  = S_RUN;
        run_cnt   = 8'd0;
        run_pcw   = 1'b1;
        run_ifw   = 1'b1;
        run_flush = 1'b0;
        run_bub   = 1'b0;
        run_stall = 1'b0;
        if (mw) begin
            run_pcw   = 1'b0;
            run_ifw   = 1'b0;
            run_stall = 1'b1;
            run_next  = S_MEMWAIT;
            run_cnt   = 8'd1;
        end else if (lu) begin
            // Flush is held off: the branch is re-evaluated once the stall clears
            run_pcw = 1'b0;
            run_ifw = 1'b0;
            run_bub = 1'b1;
            if (LU_BUBBLES > 1) begin
                run_next = S_BUBBLE;
                run_cnt  = 8'(LU_BUBBLES - 1);
            end
        end else if (Branch_taken_i) begin
            run_flush = 1'b1;
        end
    end

    // State register; reset returns to RUN with the counter cleared
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_RUN;
            cnt   <= 8'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        PCWrite_o    = 1'b1;
        IFIDWrite_o  = 1'b1;
        IFIDFlush_o  = 1'b0;
        IDEXBubble_o = 1'b0;
        PipeStall_o  = 1'b0;
        MemTimeout_o = 1'b0;
        State_o      = state;
        unique case (state)
            S_RUN: begin
                state_n      = run_next;
                cnt_n        = run_cnt;
                PCWrite_o    = run_pcw;
                IFIDWrite_o  = run_ifw;
                IFIDFlush_o  = run_flush;
                IDEXBubble_o = run_bub;
                PipeStall_o  = run_stall;
            end
            S_BUBBLE: begin
                PCWrite_o    = 1'b0;
                IFIDWrite_o  = 1'b0;
                IDEXBubble_o = 1'b1;
                if (cnt <= 8'd1) begin
                    state_n = S_RUN;
                    cnt_n   = 8'd0;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            S_MEMWAIT: begin
                if (DMem_ack_i) begin
                    // Ack releases the freeze in the same cycle
                    state_n      = run_next;
                    cnt_n        = run_cnt;
                    PCWrite_o    = run_pcw;
                    IFIDWrite_o  = run_ifw;
                    IFIDFlush_o  = run_flush;
                    IDEXBubble_o = run_bub;
                    PipeStall_o  = run_stall;
                end else begin
                    PCWrite_o   = 1'b0;
                    IFIDWrite_o = 1'b0;
                    PipeStall_o = 1'b1;
                    if (cnt >= 8'(MEM_TIMEOUT)) begin
                        state_n = S_ERR;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
            end
            S_ERR: begin
                PCWrite_o    = 1'b0;
                IFIDWrite_o  = 1'b0;
                PipeStall_o  = 1'b1;
                MemTimeout_o = 1'b1;
            end
            default: state_n = S_RUN;
        endcase
        if (rst_i) begin
            PCWrite_o    = 1'b0;
            IFIDWrite_o  = 1'b0;
            IFIDFlush_o  = 1'b0;
            IDEXBubble_o = 1'b1;
            PipeStall_o  = 1'b0;
            MemTimeout_o = 1'b0;
            State_o      = 2'd0;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating counts of PC-stalled cycles and IF/ID flushes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            StallCycles_o <= '0;
            FlushCnt_o    <= '0;
        end else begin
            if (!PCWrite_o && (StallCycles_o != '1))
                StallCycles_o <= StallCycles_o + 1'b1;
            if (IFIDFlush_o && (FlushCnt_o != '1))
                FlushCnt_o <= FlushCnt_o + 1'b1;
        end
    end
`endif

endmodule
